// File: rtl/dr_gth_frame_capture.sv
// Frame aligner: finds SYNC_WORD at any bit offset, locks, and captures payload.
// Define DR_GTH_FRAME_ERR_CNT_EN to add the LOCKED sync-error counter ports.

module dr_gth_frame_capture #(
    parameter int          DATA_WIDTH = 32,
    parameter int          DEPTH_LOG2 = 8,
    parameter logic [31:0] SYNC_WORD  = 32'h1ACF_FC1D,
    parameter int          FRAME_LEN  = 16,
    parameter int          LOCK_CNT   = 3,
    parameter int          UNLOCK_CNT = 2
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  arm,
    input  logic [DEPTH_LOG2:0]   capture_len,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  locked,
    output logic [4:0]            bit_offset,
    output logic                  capturing,
    output logic                  capture_done,
`ifdef DR_GTH_FRAME_ERR_CNT_EN
    input  logic                  err_cnt_clr,
    output logic [15:0]           sync_err_cnt,
`endif
    output logic                  capture_abort
);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    localparam int                 AW      = DEPTH_LOG2 + 1;
    localparam logic [15:0]        FLAST   = 16'(FRAME_LEN - 1);
    localparam logic [15:0]        LOCK_M1 = 16'(LOCK_CNT - 1);
    localparam logic [15:0]        UNL_M1  = 16'(UNLOCK_CNT - 1);
    localparam logic [AW-1:0]      P1      = AW'(1);
    localparam logic [AW-1:0]      DEPTH_N = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   prev_q;
    logic [4:0]              k_q;
    logic [15:0]             wcnt_q;
    logic [15:0]             good_q;
    logic [15:0]             bad_q;

    logic                    armed_q;
    logic                    cap_q;
    logic                    done_q;
    logic                    abort_q;
    logic [AW-1:0]           len_q;
    logic [AW-1:0]           iss_q;
    logic [DATA_WIDTH-1:0]   pay_q;
    logic                    pay_v_q;
    logic                    pay_last_q;
    logic [AW-1:0]           wr_ptr_q;
    logic [AW-1:0]           rd_ptr_q;
    logic [DATA_WIDTH-1:0]   rd_data_q;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   mem_q [2**DEPTH_LOG2];

    logic [63:0]             win;
    logic [31:0]             al_w;
    logic [31:0]             srch;
    logic [4:0]              hit_k;
    logic [AW-1:0]           len_d;
    logic                    hit;
    logic                    al_ok;
    logic                    bnd;
    logic                    lost;
    logic                    arm_go;
    logic                    pay_go;
    logic                    last_iss;
    logic                    wr_go;
    logic                    rd_go;

    // cand(k) = W[63-k -: 32] is the low word of W shifted right by 32-k
    assign win      = {prev_q, in_data};
    assign al_w     = 32'(win >> (7'd32 - {2'b00, k_q}));
    assign al_ok    = (al_w == SYNC_WORD);
    assign bnd      = in_valid && (state_q != HUNT) && (wcnt_q == FLAST);
    assign lost     = bnd && (state_q == LOCKED) && !al_ok && (bad_q == UNL_M1);
    assign arm_go   = arm && !cap_q;
    assign pay_go   = in_valid && (state_q == LOCKED) && !bnd && cap_q;
    assign last_iss = (iss_q == len_q - P1);
    assign wr_go    = pay_v_q && !arm_go;
    assign rd_go    = rd_en && !empty && !arm_go;

    always_comb begin
        hit   = 1'b0;
        hit_k = '0;
        srch  = '0;
        for (int k = 31; k >= 0; k--) begin
            srch = 32'(win >> (32 - k));
            if (srch == SYNC_WORD) begin
                hit   = 1'b1;
                hit_k = 5'(k);
            end
        end
    end

    always_comb begin
        len_d = capture_len;
        if (capture_len == '0 || capture_len > DEPTH_N) begin
            len_d = DEPTH_N;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state_q <= HUNT;
            prev_q  <= '0;
            k_q     <= '0;
            wcnt_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            if (in_valid) begin
                prev_q <= in_data;
                wcnt_q <= (wcnt_q == FLAST) ? 16'd0 : wcnt_q + 16'd1;
            end
            unique case (state_q)
                HUNT: begin
                    if (in_valid && hit) begin
                        k_q     <= hit_k;
                        wcnt_q  <= '0;
                        good_q  <= '0;
                        state_q <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (bnd) begin
                        if (!al_ok) begin
                            state_q <= HUNT;
                        end else if (good_q == LOCK_M1) begin
                            state_q <= LOCKED;
                            bad_q   <= '0;
                        end else begin
                            good_q <= good_q + 16'd1;
                        end
                    end
                end
                LOCKED: begin
                    if (bnd) begin
                        if (al_ok) begin
                            bad_q <= '0;
                        end else if (bad_q == UNL_M1) begin
                            state_q <= HUNT;
                        end else begin
                            bad_q <= bad_q + 16'd1;
                        end
                    end
                end
                default: state_q <= HUNT;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            armed_q    <= 1'b0;
            cap_q      <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            len_q      <= '0;
            iss_q      <= '0;
            pay_q      <= '0;
            pay_v_q    <= 1'b0;
            pay_last_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            pay_v_q    <= 1'b0;
            pay_last_q <= 1'b0;
            rd_valid_q <= 1'b0;
            if (arm_go) begin
                // an in-flight word from a finished capture is dropped with the flush
                armed_q  <= 1'b1;
                len_q    <= len_d;
                done_q   <= 1'b0;
                abort_q  <= 1'b0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_go) begin
                    wr_ptr_q <= wr_ptr_q + P1;
                    if (pay_last_q) begin
                        done_q <= 1'b1;
                    end
                end
                if (rd_go) begin
                    rd_data_q  <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
                    rd_valid_q <= 1'b1;
                    rd_ptr_q   <= rd_ptr_q + P1;
                end
                if (cap_q && lost) begin
                    cap_q   <= 1'b0;
                    done_q  <= 1'b1;
                    abort_q <= 1'b1;
                end else if (pay_go) begin
                    pay_q   <= al_w;
                    pay_v_q <= 1'b1;
                    iss_q   <= iss_q + P1;
                    if (last_iss) begin
                        pay_last_q <= 1'b1;
                        cap_q      <= 1'b0;
                    end
                end else if (!cap_q && armed_q && bnd &&
                             state_q == LOCKED && !lost) begin
                    cap_q   <= 1'b1;
                    armed_q <= 1'b0;
                    iss_q   <= '0;
                end
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESETN && wr_go) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= pay_q;
        end
    end

`ifdef DR_GTH_FRAME_ERR_CNT_EN
    logic [15:0] err_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            err_q <= '0;
        end else if (err_cnt_clr) begin
            err_q <= '0;
        end else if (bnd && state_q == LOCKED && !al_ok && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign sync_err_cnt = err_q;
`endif

    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign locked        = (state_q == LOCKED);
    assign bit_offset    = k_q;
    assign capturing     = cap_q;
    assign capture_done  = done_q;
    assign capture_abort = abort_q;

endmodule

// File: doc/dr_gth_frame_capture.md
# dr_gth_frame_capture

Frame aligner and capture buffer that sits directly downstream of the GTH receiver block and consumes its 32-bit user-data word stream. It finds a 32-bit sync word at any bit offset, locks after repeated matches at the frame period, and emits bit-aligned payload words. On software arm, it captures a programmable number of payload words into an internal buffer that a reader drains one word at a time. Upstream delivers words already synchronous to `S_AXI_ACLK`, qualified by `in_valid`.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width (fixed at 32; other values unsupported).
- `DEPTH_LOG2`, 8, capture buffer depth = 2^DEPTH_LOG2 words.
- `SYNC_WORD`, 32'h1ACF_FC1D, frame sync pattern.
- `FRAME_LEN`, 16, words per frame including the sync word; legal range 2..65535.
- `LOCK_CNT`, 3, consecutive good boundaries from VERIFY required to reach LOCKED.
- `UNLOCK_CNT`, 2, consecutive bad boundaries in LOCKED that drop to HUNT.

Ports:
- **Clock and reset (already decided):** one clock and one reset; reset is synchronous and active-low.
  - `S_AXI_ACLK`, in, 1, the only clock.
  - `S_AXI_ARESETN`, in, 1, synchronous, active-low reset.
- `in_data`, in, 32, raw receiver word.
- `in_valid`, in, 1, `in_data` qualifier.
- `arm`, in, 1, one-cycle pulse: flush the buffer and start a capture.
- `capture_len`, in, DEPTH_LOG2+1, payload words to capture; sampled on `arm`.
- `rd_en`, in, 1, pop one word.
- `rd_data`, out, 32, popped word.
- `rd_valid`, out, 1, `rd_data` valid pulse.
- `empty`, out, 1, buffer empty.
- `locked`, out, 1, aligner in LOCKED.
- `bit_offset`, out, 5, current alignment offset.
- `capturing`, out, 1, capture in progress.
- `capture_done`, out, 1, sticky; capture finished or aborted.
- `capture_abort`, out, 1, sticky; lock was lost during the capture.

## Operation
- **Alignment window:** `prev` holds the last valid word.
  - W = {prev, in_data}.
  - cand(k) = W[63-k -: 32], for k = 0..31.
  - The state machine advances only on cycles where `in_valid`=1.
- **HUNT:**
  - If any cand(k) == SYNC_WORD, the lowest k wins.
  - On a match: store k, clear the word counter and the good counter, go to VERIFY.
- **VERIFY:**
  - Each FRAME_LEN-th valid word after the sync is a boundary.
  - At each boundary, test cand(stored k).
  - Match: good++. When good == LOCK_CNT, go to LOCKED.
  - Mismatch: go to HUNT.
- **LOCKED:**
  - Boundary match: bad := 0.
  - Boundary mismatch: bad++. When bad == UNLOCK_CNT, go to HUNT.
  - Non-boundary words are payload; the aligned payload word is cand(k).
- **Arm:**
  - Flushes the buffer pointers.
  - Clears `capture_done` and `capture_abort`.
  - Latches `capture_len`; values 0 or > 2^DEPTH_LOG2 clamp to 2^DEPTH_LOG2.
  - Sets `armed`.
  - `arm` while `capturing`=1 is ignored.
- **Capture start:** armed and LOCKED at a sync boundary. Capture begins with the next payload word.
- **During capture:**
  - Payload words are written; sync words are skipped.
  - Capture continues across frames until the latched count is written, then sets `capturing`=0 and `capture_done`=1.
  - Mismatched boundaries in LOCKED do not stop the capture.
  - Leaving LOCKED stops the capture and sets both `capture_done` and `capture_abort`.
  - The buffer cannot overflow, because length ≤ depth and arm flushes the buffer.
- **Read:**
  - `rd_en` with `empty`=0 pops one word.
  - `rd_en` with `empty`=1 is ignored.
  - A write and a read in the same cycle are both performed.

## Timing
- **Reset values:** all outputs 0 except `empty`=1; state = HUNT; `prev` = 0.
- **`locked` / `bit_offset`:** registered; update on the cycle after the deciding valid word.
- **Write latency:** a buffer write occurs 2 cycles after the `in_valid` cycle carrying the word's last bits (one cycle for aligned-word register, one for write). `empty` deasserts on the cycle after the write.
- **Read latency:** `rd_data` / `rd_valid` arrive 1 cycle after `rd_en`. `rd_data` holds its value between pops.
- **`capture_done`:** asserts 1 cycle after the final write.
- **Arm vs boundary:** `arm` on the same cycle as a boundary arms but does not start; the start waits for the next boundary.
- **Reset mid-capture:** reset clears everything; buffer contents are discarded.
- **Counter width:** the word counter wraps at FRAME_LEN-1 → 0 exactly; no off-by-one across the wrap.

## Configuration
- Macro: `DR_GTH_FRAME_ERR_CNT_EN`.
- **Defined:**
  - Adds output `sync_err_cnt` [15:0]: a saturating count of mismatched boundaries while LOCKED.
  - Adds input `err_cnt_clr`, which clears the count.
  - Both reset to 0; the count saturates at 16'hFFFF.
- **Undefined:** the counter and both ports are absent, and behaviour is otherwise identical.

## Test plan
- **Lock at an offset:** stream SYNC_WORD shifted by 7 bits every 16 words → `locked`=1 after the 3rd verified boundary, `bit_offset`=7.
- **Capture run:** while locked, `arm` with `capture_len`=20 → 20 payload words buffered in order, sync words excluded, `capture_done`=1, `capture_abort`=0.
- **Lock loss mid-capture:** corrupt 2 consecutive sync words during a capture → `locked`=0, `capturing`=0, `capture_done`=1, `capture_abort`=1, and the words captured so far remain readable.
- **Single bad boundary:** one corrupt sync word in LOCKED → lock is held and the capture continues; with `DR_GTH_FRAME_ERR_CNT_EN`, `sync_err_cnt`=1.
- **Read path:** `rd_en` on empty → no `rd_valid`; simultaneous write and read at 1 word buffered → occupancy stays 1.
- **Clamp and stalls:** `capture_len`=0 → 256 words captured; gaps in `in_valid` → identical buffer contents.
